// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader's view; slave is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            byteIn;
  logic                  byteValid;
  logic                  byteReady;
  logic                  imemWe;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [31:0]           imemWdata;

  modport master (
    input  byteIn, byteValid,
    output byteReady, imemWe, imemAddr, imemWdata
  );

  modport slave (
    output byteIn, byteValid,
    input  byteReady, imemWe, imemAddr, imemWdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: byte stream -> little-endian words -> instruction memory, holding the CPU until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpuHold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         wordCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK  = 3'd4,
`endif
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CHECK;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t                state_r, state_nx;
  logic [7:0]            count_lo_r;
  logic [15:0]           count_r;
  logic [15:0]           word_cnt_r;
  logic [1:0]            byte_idx_r;
  logic [23:0]           asm_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  we_r;
  logic                  ready_r, busy_r, hold_r, done_r, error_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_r;
`endif

  logic                  accept_s;
  logic                  start_load_s;
  logic                  active_nx_s;
  logic [15:0]           hdr_count_s;

  assign accept_s     = bus.byteValid && ready_r;
  assign start_load_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
  assign hdr_count_s  = {bus.byteIn, count_lo_r};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; every transition out of a streaming state happens on an accepted byte
  always_comb begin
    state_nx    = state_r;
    active_nx_s = 1'b0;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start_load_s) state_nx = HDR_LO;
        else              state_nx = state_r;
      end
      HDR_LO: begin
        if (accept_s) state_nx = HDR_HI;
        else          state_nx = state_r;
      end
      HDR_HI: begin
        if (!accept_s)                          state_nx = state_r;
        else if ({1'b0, hdr_count_s} > CAPACITY) state_nx = ERR;
        else if (hdr_count_s == 16'd0)          state_nx = AFTER_PAYLOAD;
        else                                    state_nx = DATA;
      end
      DATA: begin
        if (accept_s && (byte_idx_r == 2'd3) && ((word_cnt_r + 16'd1) == count_r))
          state_nx = AFTER_PAYLOAD;
        else
          state_nx = state_r;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (!accept_s)                   state_nx = state_r;
        else if (bus.byteIn == csum_r)   state_nx = DONE;
        else                             state_nx = ERR;
      end
`endif
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      HDR_LO, HDR_HI, DATA: active_nx_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:                active_nx_s = 1'b1;
`endif
      default:              active_nx_s = 1'b0;
    endcase
  end

  // Datapath: header capture, word assembly, write port and registered status outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_lo_r <= 8'd0;
      count_r    <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_idx_r <= 2'd0;
      asm_r      <= 24'd0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      hold_r     <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      we_r <= 1'b0;
      // Address advances once the pulse has presented it to the memory
      if (we_r) addr_r <= addr_r + ADDR_WIDTH'(1);
      if (start_load_s) begin
        done_r     <= 1'b0;
        error_r    <= 1'b0;
        word_cnt_r <= 16'd0;
        addr_r     <= '0;
        byte_idx_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_r     <= 8'd0;
`endif
      end
      if (accept_s && (state_r == HDR_LO)) count_lo_r <= bus.byteIn;
      if (accept_s && (state_r == HDR_HI)) count_r    <= hdr_count_s;
      if (accept_s && (state_r == DATA)) begin
        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_r     <= csum_r ^ bus.byteIn;
`endif
        case (byte_idx_r)
          2'd0:    asm_r[7:0]   <= bus.byteIn;
          2'd1:    asm_r[15:8]  <= bus.byteIn;
          2'd2:    asm_r[23:16] <= bus.byteIn;
          default: begin
            wdata_r    <= {bus.byteIn, asm_r};
            we_r       <= 1'b1;
            word_cnt_r <= word_cnt_r + 16'd1;
          end
        endcase
      end
      if (state_nx == DONE) done_r  <= 1'b1;
      if (state_nx == ERR)  error_r <= 1'b1;
      ready_r <= active_nx_s;
      busy_r  <= active_nx_s;
      hold_r  <= (state_nx != DONE);
    end
  end

  assign bus.byteReady = ready_r;
  assign bus.imemWe    = we_r;
  assign bus.imemAddr  = addr_r;
  assign bus.imemWdata = wdata_r;
  assign cpuHold       = hold_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign wordCount     = word_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, good loads (back-to-back and gapped), oversize header,
// empty image, mid-load reset, and checksum pass/fail when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int AW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cpuHold, busy, done, error;
  logic [15:0] wordCount;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus.master),
    .cpuHold   (cpuHold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .wordCount (wordCount)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  logic [7:0]  stream[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // Write and byte-acceptance monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (bus.imemWe === 1'b1) begin
      wr_addr.push_back(32'(bus.imemAddr));
      wr_data.push_back(bus.imemWdata);
    end
    if (reset && bus.byteValid && bus.byteReady) n_acc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bus.byteValid = 1'b0;
    repeat (gap) tick();
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    while (bus.byteReady !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 32'(bus.byteReady), 32'd1);
    tick();
  endtask

  task automatic send_stream(input int max_gap, input bit chk_write);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], int'($urandom_range(max_gap, 0)));
      if (chk_write && i == 5) begin
        check("first_we",    32'(bus.imemWe),   32'd1);
        check("first_addr",  32'(bus.imemAddr), 32'd0);
        check("first_wdata", bus.imemWdata,     32'h0000_0013);
      end
    end
    bus.byteValid = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_good_stream();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h90);
`endif
  endtask

  task automatic check_two_words(input string pfx);
    check({pfx, "_nwr"},  32'(wr_addr.size()), 32'd2);
    check({pfx, "_a0"},   (wr_addr.size() > 0) ? wr_addr[0] : 32'hxxxx_xxxx, 32'd0);
    check({pfx, "_d0"},   (wr_data.size() > 0) ? wr_data[0] : 32'hxxxx_xxxx, 32'h0000_0013);
    check({pfx, "_a1"},   (wr_addr.size() > 1) ? wr_addr[1] : 32'hxxxx_xxxx, 32'd1);
    check({pfx, "_d1"},   (wr_data.size() > 1) ? wr_data[1] : 32'hxxxx_xxxx, 32'h0010_0093);
    check({pfx, "_wcnt"}, 32'(wordCount), 32'd2);
  endtask

  task automatic check_done(input string pfx);
    check({pfx, "_done"},  32'(done),    32'd1);
    check({pfx, "_error"}, 32'(error),   32'd0);
    check({pfx, "_hold"},  32'(cpuHold), 32'd0);
    check({pfx, "_busy"},  32'(busy),    32'd0);
  endtask

  initial begin
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    check("rst_ready", 32'(bus.byteReady), 32'd0);
    check("rst_we",    32'(bus.imemWe),    32'd0);
    check("rst_addr",  32'(bus.imemAddr),  32'd0);
    check("rst_wdata", bus.imemWdata,      32'd0);
    check("rst_hold",  32'(cpuHold),       32'd1);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_done",  32'(done),          32'd0);
    check("rst_error", 32'(error),         32'd0);
    check("rst_wcnt",  32'(wordCount),     32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back load
    load_good_stream();
    wr_addr.delete(); wr_data.delete(); n_acc = 0;
    pulse_start();
    check("start_busy",  32'(busy),          32'd1);
    check("start_ready", 32'(bus.byteReady), 32'd1);
    send_stream(0, 1'b1);
    check_two_words("b2b");
    check_done("b2b");
    check("b2b_we_low", 32'(bus.imemWe), 32'd0);
    check("b2b_nacc",   32'(n_acc),      32'(stream.size()));

    // Gapped load with a start pulse while busy
    wr_addr.delete(); wr_data.delete(); n_acc = 0;
    pulse_start();
    check("gap_done_cleared", 32'(done), 32'd0);
    check("gap_hold_set",     32'(cpuHold), 32'd1);
    send_byte(stream[0], int'($urandom_range(3, 0)));
    send_byte(stream[1], int'($urandom_range(3, 0)));
    bus.byteValid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", 32'(busy), 32'd1);
    for (int i = 2; i < stream.size(); i++) send_byte(stream[i], int'($urandom_range(3, 0)));
    bus.byteValid = 1'b0;
    tick();
    check_two_words("gap");
    check_done("gap");
    check("gap_nacc", 32'(n_acc), 32'(stream.size()));

    // Oversize header: N = 257
    wr_addr.delete(); wr_data.delete();
    stream = '{8'h01, 8'h01};
    pulse_start();
    send_stream(0, 1'b0);
    check("ovr_error", 32'(error),         32'd1);
    check("ovr_ready", 32'(bus.byteReady), 32'd0);
    check("ovr_hold",  32'(cpuHold),       32'd1);
    check("ovr_done",  32'(done),          32'd0);
    check("ovr_nwr",   32'(wr_addr.size()), 32'd0);

    // Empty image, with start raised alongside the final byte
    wr_addr.delete(); wr_data.delete();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    pulse_start();
    check("empty_err_cleared", 32'(error), 32'd0);
    for (int i = 0; i < stream.size() - 1; i++) send_byte(stream[i], 0);
    start = 1'b1;
    send_byte(stream[stream.size() - 1], 0);
    start = 1'b0;
    bus.byteValid = 1'b0;
    tick();
    check_done("empty");
    check("empty_wcnt", 32'(wordCount),      32'd0);
    check("empty_nwr",  32'(wr_addr.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words are written, load flagged as failed
    wr_addr.delete(); wr_data.delete();
    load_good_stream();
    stream[10] = 8'h91;
    pulse_start();
    send_stream(0, 1'b1);
    check_two_words("csum_bad");
    check("csum_bad_error", 32'(error),   32'd1);
    check("csum_bad_done",  32'(done),    32'd0);
    check("csum_bad_hold",  32'(cpuHold), 32'd1);
`endif

    // Reset after the second data byte
    wr_addr.delete(); wr_data.delete();
    load_good_stream();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
    bus.byteValid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_busy",  32'(busy),          32'd0);
    check("mid_ready", 32'(bus.byteReady), 32'd0);
    check("mid_wcnt",  32'(wordCount),     32'd0);
    check("mid_hold",  32'(cpuHold),       32'd1);
    repeat (4) tick();
    check("mid_nwr",   32'(wr_addr.size()), 32'd0);

    // Fresh load after the interrupted one
    pulse_start();
    send_stream(0, 1'b1);
    check_two_words("fresh");
    check_done("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory read by the single-cycle datapath's fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction-memory write port. It holds the datapath in reset until a complete, well-formed image has been written. It is the writer side of the instruction-memory interface; the fetch path remains the reader.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byteIn  in  8  stream data byte
- byteValid  in  1  byteIn is valid
- byteReady  out  1  loader can accept a byte this cycle
- imemWe  out  1  instruction-memory write enable; one-cycle pulse per word
- imemAddr  out  ADDR_WIDTH  word address of the current write
- imemWdata  out  32  word being written
- cpuHold  out  1  high means the datapath's reset is held asserted
- busy  out  1  a load is in progress
- done  out  1  sticky; the last load completed successfully
- error  out  1  sticky; the last load failed
- wordCount  out  16  number of words written in the current or last load

## Operation
- Stream format: count low byte, count high byte (16-bit word count N), then N words of 4 bytes each, with the least-significant byte first. A checksum byte follows only when the configuration macro is defined.
- A byte transfers on a rising edge where byteValid && byteReady.
- byteReady=1 in HDR_LO, HDR_HI, DATA and CHECK. It is 0 in all other states.
- States and transitions:
  - IDLE: on start, go to HDR_LO and clear done, error, wordCount and the checksum.
  - HDR_LO: latch count[7:0], then go to HDR_HI.
  - HDR_HI: latch count[15:8]. If N > 2**ADDR_WIDTH, go to ERR. If N == 0, go to CHECK when enabled, otherwise DONE. Else go to DATA.
  - DATA: shift in bytes, with byte k going to bits 8k+7:8k. When the 4th byte is accepted, register the word and pulse the write. After the Nth word, go to CHECK when enabled, otherwise DONE.
  - CHECK: compare the received byte with the running XOR. On a match go to DONE; otherwise go to ERR.
  - DONE: set done=1 and release cpuHold. On start, begin a new load.
  - ERR: set error=1 and keep cpuHold=1. On start, begin a new load.
- imemAddr starts at 0 for each load and increments by 1 after every write. Wrap-around is impossible because oversized counts are rejected in HDR_HI.
- wordCount increments with each imemWe pulse.
- start is ignored while busy=1.
- cpuHold=1 in every state except DONE. busy=1 in HDR_LO, HDR_HI, DATA and CHECK.

## Timing
- Reset (reset=0 at an edge) takes effect on that edge and may occur mid-load.
  - Reset values: state IDLE, byteReady=0, imemWe=0, imemAddr=0, imemWdata=0, cpuHold=1, busy=0, done=0, error=0, wordCount=0.
  - A partially assembled word is discarded and not written.
- The loader accepts one byte per cycle at most; a back-to-back stream is accepted with no bubbles.
- Write latency: imemWe is high for exactly one cycle, the cycle after the edge that accepted the word's 4th byte. imemAddr and imemWdata are valid in that same cycle.
- An FSM transition occurs on the edge that accepts the byte. done, error and cpuHold update registered, on the edge after the final header, checksum or data byte.
- Gaps in byteValid stall the FSM with no state change.
- start arriving in the same cycle as the final byte has no effect.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CHECK state present.
  - The running XOR covers all payload bytes; header bytes are excluded.
  - One trailing checksum byte is required, including when N=0, where the expected checksum is 0x00.
  - Words are written before the check, so a checksum mismatch leaves memory written but sets error=1 and keeps cpuHold=1.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state and no checksum logic. The load ends at DONE immediately after the Nth word, or directly after HDR_HI when N=0.

## Test plan
- Reset check: hold reset=0 for 2 cycles. Required: all outputs at their reset values, and cpuHold=1.
- Load with IMEM_LOADER_CHECKSUM_EN undefined: start, then stream 02 00 13 00 00 00 93 00 10 00 back-to-back. Required:
  - imemWe pulses at addr 0 with data 0x00000013, and at addr 1 with data 0x00100093.
  - Afterwards done=1, cpuHold=0, wordCount=2.
- Same load with random byteValid gaps: identical writes and final state, and each byte is accepted exactly once.
- Oversize header with ADDR_WIDTH=8, stream 01 01 (N=257). Required: error=1, byteReady=0, no imemWe pulse, cpuHold=1.
- Checksum with IMEM_LOADER_CHECKSUM_EN defined, using the two-word payload above:
  - Trailing byte 0x90: done=1.
  - Trailing byte 0x91: error=1, cpuHold=1, and both words still written.
- Reset mid-load: apply reset=0 after the 2nd data byte. Required: state returns to IDLE, no write occurs, wordCount=0. A fresh start then loads correctly.
